// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the MAC sequencer slice.
// f8 format: sign, 4-bit exponent (bias 7, no inf/nan), 3-bit mantissa, subnormals at exp 0.
package mac_seq_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mac_seq_state_e;

    // Unsigned magnitude of an f8 code in units of 2^-9 (the smallest subnormal).
    function automatic logic [17:0] f8_mag(input logic [DATA_W-1:0] f);
        logic [3:0] mant;
        logic [3:0] sh;
        if (f[6:3] == 4'd0) begin
            mant = {1'b0, f[2:0]};
            sh   = 4'd0;
        end else begin
            mant = {1'b1, f[2:0]};
            sh   = f[6:3] - 4'd1;
        end
        return 18'(mant) << sh;
    endfunction

endpackage

// File: rtl/multiply_by_2.sv
// Combinational MAC lane: out = cumulative + weight * value, signed int8 or f8.
// Both modes saturate; float rounds toward zero and flags results at or above 512.0.
module multiply_by_2
    import mac_seq_pkg::*;
(
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] value,
    input  logic [DATA_W-1:0] cumulative,
    input  logic              float_mode,
    output logic [DATA_W-1:0] out,
    output logic              overflow
);

    // Integer path
    logic signed [15:0] i_prod;
    logic        [16:0] i_sum;
    logic               i_ovf;
    logic [DATA_W-1:0]  i_out;

    assign i_prod = $signed(weight) * $signed(value);
    assign i_sum  = {i_prod[15], i_prod} + {{9{cumulative[7]}}, cumulative};
    assign i_ovf  = (i_sum[16:7] != 10'h000) && (i_sum[16:7] != 10'h3FF);
    assign i_out  = i_ovf ? (i_sum[16] ? 8'h80 : 8'h7F) : i_sum[7:0];

    // Float path: exact fixed-point sum in units of 2^-18, then truncate back to f8
    logic [35:0]       f_pmag;
    logic [39:0]       f_prod;
    logic [39:0]       f_acc;
    logic [39:0]       f_sum;
    logic              f_neg;
    logic [38:0]       f_mag;
    logic [4:0]        msb;
    logic [2:0]        mant;
    logic              f_ovf;
    logic [DATA_W-1:0] f_out;

    assign f_pmag = f8_mag(weight) * f8_mag(value);
    assign f_prod = (weight[7] ^ value[7]) ? -{4'b0, f_pmag} : {4'b0, f_pmag};
    assign f_acc  = cumulative[7] ? -{13'b0, f8_mag(cumulative), 9'b0}
                                  : {13'b0, f8_mag(cumulative), 9'b0};
    assign f_sum  = f_prod + f_acc;
    assign f_neg  = f_sum[39];
    assign f_mag  = f_neg ? 39'(-f_sum) : f_sum[38:0];

    always_comb begin
        f_ovf = 1'b0;
        f_out = '0;
        msb   = 5'd0;
        mant  = 3'd0;
        if (f_mag[38:27] != '0) begin
            f_ovf = 1'b1;
            f_out = {f_neg, 7'h7F};
        end else if (f_mag[26:12] == '0) begin
            // Subnormal range; a value truncated to zero is emitted as +0
            f_out = (f_mag[11:9] == 3'd0) ? 8'h00 : {f_neg, 4'd0, f_mag[11:9]};
        end else begin
            for (int i = 12; i < 27; i++) begin
                if (f_mag[i]) msb = 5'(i);
            end
            mant  = 3'(f_mag[26:0] >> (msb - 5'd3));
            f_out = {f_neg, 4'(msb - 5'd11), mant};
        end
    end

    assign out      = float_mode ? f_out : i_out;
    assign overflow = float_mode ? f_ovf : i_ovf;

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one MAC lane over a job of up to MAX_LEN weight/value pairs.
// Define OVF_HALT_EN to end a job at the first lane overflow.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              float_mode,
    input  logic [DATA_W-1:0] init_acc,
    output logic              busy,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] value,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic [LEN_W-1:0]  count
);

    mac_seq_state_e    state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              mode_q, mode_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] lane_out;
    logic              lane_ovf;
    logic              fire;
    logic [LEN_W-1:0]  len_clamped;

    multiply_by_2 u_mac (
        .weight    (weight),
        .value     (value),
        .cumulative(acc_q),
        .float_mode(mode_q),
        .out       (lane_out),
        .overflow  (lane_ovf)
    );

    assign fire        = (state_q == RUN) && op_valid;
    assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = float_mode;
                    len_d   = len_clamped;
                    acc_d   = init_acc;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = (len_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fire) begin
                    acc_d   = lane_out;
                    ovf_d   = ovf_q | lane_ovf;
                    count_d = count_q + LEN_W'(1);
                    if (count_q == len_q - LEN_W'(1)) state_d = DONE;
`ifdef OVF_HALT_EN
                    if (lane_ovf) state_d = DONE;
`endif
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even alongside res_ready
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign op_ready  = (state_q == RUN);
    assign res_valid = (state_q == DONE);
    assign result    = acc_q;
    assign ovf       = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized self-checking bench for mac_sequencer against a real-valued reference model.
module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] len;
    logic       float_mode;
    logic [7:0] init_acc;
    logic       busy;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] weight;
    logic [7:0] value;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] result;
    logic       ovf;
    logic [6:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] w_arr [0:63];
    logic [7:0] v_arr [0:63];

    always #5 clk = ~clk;

    mac_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .float_mode(float_mode),
        .init_acc  (init_acc),
        .busy      (busy),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .weight    (weight),
        .value     (value),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .ovf       (ovf),
        .count     (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Real value of an f8 code: exp 0 is m * 2^-9, otherwise (8+m) * 2^(e-10)
    function automatic real f8_val(input logic [7:0] b);
        real mag;
        int  e;
        e = int'(b[6:3]);
        if (e == 0) begin
            mag = real'(int'(b[2:0]));
            for (int k = 0; k < 9; k++) mag = mag / 2.0;
        end else begin
            mag = real'(8 + int'(b[2:0]));
            if (e >= 10) for (int k = 0; k < e - 10; k++) mag = mag * 2.0;
            else         for (int k = 0; k < 10 - e; k++) mag = mag / 2.0;
        end
        return b[7] ? -mag : mag;
    endfunction

    task automatic model_step(input bit fm, input logic [7:0] acc, input logic [7:0] w,
                              input logic [7:0] v, output logic [7:0] r, output bit o);
        int  s;
        real x;
        real ax;
        int  code;
        if (!fm) begin
            s = int'($signed(acc)) + int'($signed(w)) * int'($signed(v));
            o = (s > 127) || (s < -128);
            r = (s > 127) ? 8'h7F : (s < -128) ? 8'h80 : 8'(s);
        end else begin
            x  = f8_val(w) * f8_val(v) + f8_val(acc);
            ax = (x < 0.0) ? -x : x;
            if (ax >= 512.0) begin
                o = 1'b1;
                r = {(x < 0.0), 7'h7F};
            end else begin
                o    = 1'b0;
                code = 0;
                // Round toward zero: largest representable magnitude not above |x|
                for (int k = 1; k < 128; k++) if (f8_val(8'(k)) <= ax) code = k;
                r = (code == 0) ? 8'h00 : {(x < 0.0), 7'(code)};
            end
        end
    endtask

    task automatic model_job(input bit fm, input int lq, input logic [7:0] init,
                             output logic [7:0] r, output bit o, output int c);
        logic [7:0] acc;
        logic [7:0] nxt;
        bit         so;
        bit         halt;
        acc  = init;
        o    = 1'b0;
        c    = 0;
        halt = 1'b0;
        for (int i = 0; i < lq; i++) begin
            if (!halt) begin
                model_step(fm, acc, w_arr[i], v_arr[i], nxt, so);
                acc = nxt;
                o   = o | so;
                c++;
`ifdef OVF_HALT_EN
                if (so) halt = 1'b1;
`endif
            end
        end
        r = acc;
    endtask

    // gold < 0 means no extra directed expectation on the result
    task automatic run_job(input bit fm, input int ln, input logic [7:0] init,
                           input bit gaps, input int hold, input int gold);
        logic [7:0] er;
        bit         eo;
        int         ec;
        int         lq;
        int         idx;
        int         cyc;
        bit         fired;
        lq = (ln > 64) ? 64 : ln;
        model_job(fm, lq, init, er, eo, ec);
        @(negedge clk);
        start = 1'b1; len = 7'(ln); float_mode = fm; init_acc = init;
        @(negedge clk);
        start = 1'b0; len = 7'($urandom); init_acc = 8'($urandom);
        check_eq("busy_after_start", 32'(busy), 32'd1);
        if (lq == 0) begin
            check_eq("len0_res_valid", 32'(res_valid), 32'd1);
            check_eq("len0_op_ready", 32'(op_ready), 32'd0);
        end
        idx = 0;
        cyc = 0;
        while (!res_valid && cyc < 400) begin
            fired      = op_ready && (!gaps || cyc[0]);
            op_valid   = fired;
            weight     = (idx < 64) ? w_arr[idx] : 8'h00;
            value      = (idx < 64) ? v_arr[idx] : 8'h00;
            float_mode = 1'($urandom);
            @(negedge clk);
            if (fired) begin
                idx++;
                if (idx == ec) check_eq("res_valid_latency", 32'(res_valid), 32'd1);
            end
            cyc++;
        end
        op_valid = 1'b0;
        check_eq("res_valid_reached", 32'(res_valid), 32'd1);
        check_eq("pairs_accepted", 32'(idx), 32'(ec));
        check_eq("result", 32'(result), 32'(er));
        check_eq("ovf", 32'(ovf), 32'(eo));
        check_eq("count", 32'(count), 32'(ec));
        if (gold >= 0) check_eq("result_gold", 32'(result), 32'(gold));
        for (int h = 0; h < hold; h++) begin
            start = 1'($urandom);
            @(negedge clk);
            check_eq("hold_valid", 32'(res_valid), 32'd1);
            check_eq("hold_result", 32'(result), 32'(er));
            check_eq("hold_ovf", 32'(ovf), 32'(eo));
            check_eq("hold_count", 32'(count), 32'(ec));
        end
        res_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        check_eq("retire_idle", 32'(busy), 32'd0);
        res_ready = 1'b0;
        start     = 1'b0;
    endtask

    function automatic logic [7:0] gen_f8();
        return {1'($urandom), 4'($urandom_range(2, 9)), 3'($urandom)};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; float_mode = 1'b0; init_acc = '0;
        op_valid = 1'b0; weight = '0; value = '0; res_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin w_arr[i] = '0; v_arr[i] = '0; end
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_op_ready", 32'(op_ready), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        rst = 1'b0;

        // Signed int dot product
        w_arr[0] = 8'd2; v_arr[0] = 8'd3;
        w_arr[1] = 8'd4; v_arr[1] = 8'd5;
        w_arr[2] = 8'hFF; v_arr[2] = 8'd6;
        run_job(1'b0, 3, 8'h00, 1'b0, 0, 8'h14);

        // Saturation
        for (int i = 0; i < 3; i++) begin w_arr[i] = 8'd127; v_arr[i] = 8'd1; end
        run_job(1'b0, 3, 8'h00, 1'b0, 0, 8'h7F);

        // Empty job
        run_job(1'b0, 0, 8'h05, 1'b0, 0, 8'h05);

        // Operand gaps, then result backpressure with start pulses
        for (int i = 0; i < 4; i++) begin w_arr[i] = 8'($urandom); v_arr[i] = 8'($urandom_range(0, 6) - 3); end
        run_job(1'b0, 4, 8'h09, 1'b1, 0, -1);
        run_job(1'b0, 4, 8'h09, 1'b0, 5, -1);

        // Reset mid-job
        for (int i = 0; i < 4; i++) begin w_arr[i] = 8'd1; v_arr[i] = 8'd1; end
        @(negedge clk);
        start = 1'b1; len = 7'd4; float_mode = 1'b0; init_acc = 8'h11;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin op_valid = 1'b1; @(negedge clk); end
        op_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_op_ready", 32'(op_ready), 32'd0);
        check_eq("abort_res_valid", 32'(res_valid), 32'd0);
        check_eq("abort_count", 32'(count), 32'd0);
        w_arr[0] = 8'd3; v_arr[0] = 8'd3;
        run_job(1'b0, 1, 8'h01, 1'b0, 0, 10);

        // Float: 1.0 + 1.0 * 2.0 = 3.0
        w_arr[0] = 8'h38; v_arr[0] = 8'h40;
        run_job(1'b1, 1, 8'h38, 1'b0, 0, 8'h44);

        // Random jobs, including over-length requests that clamp
        for (int j = 0; j < 40; j++) begin
            bit         fm;
            int         ln;
            logic [7:0] init;
            fm = 1'($urandom);
            ln = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 127))
                                              : int'($urandom_range(0, 12));
            for (int i = 0; i < 64; i++) begin
                if (fm) begin
                    w_arr[i] = gen_f8();
                    v_arr[i] = gen_f8();
                end else begin
                    w_arr[i] = 8'($urandom);
                    v_arr[i] = 8'($urandom_range(0, 6) - 3);
                end
            end
            init = fm ? gen_f8() : 8'($urandom);
            run_job(fm, ln, init, 1'($urandom), int'($urandom_range(0, 3)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
